// File: rtl/seg7_scan_if.sv
// Load handshake, display controls and digit drive shared between the scan
// controller (slave) and its requester/observer (master).
interface seg7_scan_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        lz_blank;
  logic        blink;
  logic [3:0]  digit_value;
  logic [3:0]  digit_an_n;

  modport master (
    output load_valid, load_data, lz_blank, blink,
    input  load_ready, digit_value, digit_an_n
  );

  modport slave (
    input  load_valid, load_data, lz_blank, blink,
    output load_ready, digit_value, digit_an_n
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a two-entry load buffer.
// Optional blinking is compiled in with `define SEG7_SCAN_CTRL_BLINK_EN.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input logic         clk,
  input logic         rst_n,
  seg7_scan_if.slave  bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [15:0]      disp_q, disp_d;
  logic [0:0]       state_q, state_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       val_q, val_d;

  logic        tick, frame_bnd, commit, xfer;
  logic        blink_dark, lz_dark, dark;
  logic [3:0]  shamt;
  logic [15:0] hi_digits;

  always_comb begin
    tick        = (cnt_q == CNT_MAX);
    frame_bnd   = tick && (idx_q == 2'd3);
    commit      = frame_bnd && pend_full_q;
    xfer        = bus.load_valid && !pend_full_q;

    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    idx_d       = tick ? idx_q + 2'd1 : idx_q;

    pend_d      = xfer ? bus.load_data : pend_q;
    pend_full_d = pend_full_q;
    if (xfer)
      pend_full_d = 1'b1;
    else if (commit)
      pend_full_d = 1'b0;

    disp_d      = commit ? pend_q : disp_q;
    state_d     = commit ? ST_SHOW : state_q;
  end

`ifdef SEG7_SCAN_CTRL_BLINK_EN
  localparam int FC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(BLINK_DIV - 1);

  logic [FC_W-1:0] fc_q, fc_d;
  logic            phase_q, phase_d;

  always_comb begin
    fc_d    = fc_q;
    phase_d = phase_q;
    if (frame_bnd) begin
      if (fc_q == FC_MAX) begin
        fc_d    = '0;
        phase_d = !phase_q;
      end else begin
        fc_d    = fc_q + 1'b1;
      end
    end
    blink_dark = bus.blink && phase_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_q    <= '0;
      phase_q <= 1'b0;
    end else begin
      fc_q    <= fc_d;
      phase_q <= phase_d;
    end
  end
`else
  wire unused_blink = bus.blink;
  assign blink_dark = 1'b0;
`endif

  // Output stage: the drive for the slot currently selected by idx_q, one clock later.
  always_comb begin
    shamt     = {idx_q, 2'b00};
    hi_digits = disp_q >> shamt;
    lz_dark   = bus.lz_blank && (idx_q != 2'd0) && (hi_digits == 16'h0000);
    dark      = (state_q == ST_BLANK) || blink_dark || lz_dark;
    an_d      = dark ? 4'b1111 : ~(4'b0001 << idx_q);
    val_d     = dark ? 4'h0 : disp_q[shamt +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      pend_q      <= 16'h0000;
      pend_full_q <= 1'b0;
      disp_q      <= 16'h0000;
      state_q     <= ST_BLANK;
      an_q        <= 4'b1111;
      val_q       <= 4'h0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      disp_q      <= disp_d;
      state_q     <= state_d;
      an_q        <= an_d;
      val_q       <= val_d;
    end
  end

  assign bus.load_ready  = !pend_full_q;
  assign bus.digit_an_n  = an_q;
  assign bus.digit_value = val_q;

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clocks per digit slot (legal range 2..2^20).
REQ-002 SHALL have parameter BLINK_DIV, default 64, full scan frames per blink half-period (legal range 1..255).
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load_valid  in  1  requester offers load_data.
REQ-006 SHALL have port load_ready  out  1  block can accept load_data.
REQ-007 SHALL have port load_data  in  16  four hex digits; [3:0] is digit 0 (rightmost).
REQ-008 SHALL have port lz_blank  in  1  enables leading-zero blanking.
REQ-009 SHALL have port blink  in  1  requests display blinking.
REQ-010 SHALL have port digit_value  out  4  nibble for the shared downstream hex-to-7-segment decoder.
REQ-011 SHALL have port digit_an_n  out  4  one-hot active-low digit enable; 4'b1111 = all dark.

Function
REQ-012 Prescaler counts 0..SCAN_DIV-1 and wraps; "tick" = the cycle with count == SCAN_DIV-1.
REQ-013 Scan index (2 bits) advances 0->1->2->3->0 on each tick; "frame boundary" = tick with index == 3.
REQ-014 digit_value and digit_an_n are registered; they reflect the new scan index exactly 1 clock after the tick edge.
REQ-015 Two-entry buffer: pending register (plus full flag) and display register.
REQ-016 Load transfer when load_valid && load_ready; load_ready = !pending_full (combinational from the flag only, never from load_valid).
REQ-017 Transfer writes load_data to pending and sets pending_full.
REQ-018 On a frame boundary with pending_full = 1: pending is copied to display, pending_full clears, and load_ready rises the following cycle.
REQ-019 A transfer on a frame-boundary cycle (pending empty) is held in pending and commits at the next frame boundary, never the current one.
REQ-020 FSM states: BLANK (no value committed since reset) and SHOW; BLANK->SHOW on the first commit; SHOW is left only by reset.
REQ-021 In BLANK, digit_an_n = 4'b1111 and digit_value = 4'h0 for every slot.
REQ-022 In SHOW, active slot i drives digit_value = display[4i+3:4i] and digit_an_n with bit i low, unless blanked per REQ-023/REQ-024.
REQ-023 With lz_blank = 1, digit i (i = 3..1) is blanked when it and every higher digit are zero; digit 0 is never blanked; a blanked slot drives digit_an_n = 4'b1111 and digit_value = 4'h0.
REQ-024 With blink = 1 and blink phase = 1, all slots are blanked as in REQ-023.
REQ-025 lz_blank and blink are sampled every cycle; there is no latching.

Reset
REQ-026 While rst_n = 0: prescaler = 0, scan index = 0, pending_full = 0, pending = display = 16'h0000, state = BLANK, blink phase = 0, frame counter = 0, digit_an_n = 4'b1111, digit_value = 4'h0, load_ready = 1.
REQ-027 Reset asserted mid-frame or with pending_full = 1 discards all held data; after release, operation restarts from slot 0 with the first tick at clock SCAN_DIV.

Configuration
REQ-028 Macro SEG7_SCAN_CTRL_BLINK_EN defined: a frame counter (0..BLINK_DIV-1) increments on each frame boundary; on wrap, blink phase toggles; blink functions per REQ-024.
REQ-029 Macro SEG7_SCAN_CTRL_BLINK_EN undefined: the frame counter and blink phase are absent, the blink input is ignored, and the port remains present.

Verification (SCAN_DIV=4, BLINK_DIV=2)
REQ-030 Reset, then no load for 64 clocks -> digit_an_n = 4'b1111 throughout; load_ready = 1.
REQ-031 Load 16'h12AF at clock 2 -> load_ready = 0 next cycle; at the frame boundary (clock 15) commit; the next frame shows slots F,A,2,1 with digit_an_n 1110,1101,1011,0111, 4 clocks each.
REQ-032 Load 16'h0001 then 16'h0002 back-to-back -> second offer stalls (load_ready = 0) until the boundary; 0001 is displayed one frame before 0002.
REQ-033 lz_blank = 1 with display 16'h0000 -> only slot 0 is lit showing 0; with 16'h0300 -> slots 0,1,2 are lit and slot 3 is dark.
REQ-034 With the macro defined, blink = 1 -> 2 frames lit and 2 frames dark, repeating; with the macro undefined -> always lit.
REQ-035 Assert rst_n = 0 in slot 2 with pending_full = 1 -> the REQ-026 values appear asynchronously; after release the display is BLANK and load_ready = 1.
